// File: rtl/swara_dec_pkg.sv
// Shared constants for the swara decoder: note thresholds, silence code,
// envelope codes, FSM states and small arithmetic helpers.
package swara_dec_pkg;

    localparam int         N_TH       = 20;
    localparam int         SILENT_MIN = 48;
    localparam logic [4:0] SWARA_DC   = 5'd31;
    localparam logic [9:0] ZC_MAX     = 10'd1023;

    typedef enum logic [1:0] {
        WIN_NONE = 2'd0,
        WIN_ASC  = 2'd1,
        WIN_FALL = 2'd2,
        WIN_BOTH = 2'd3
    } win_e;

    typedef enum logic [1:0] {
        ST_ACCUM  = 2'd0,
        ST_SEARCH = 2'd1,
        ST_OUT    = 2'd2
    } state_e;

    // TH[k] = round(96 * 2^((k-0.5)/7)); the ratio 1.104089514 is 2^(1/7).
    function automatic logic [9:0] th(input logic [4:0] k);
        case (k)
            5'd1:    return 10'd101;
            5'd2:    return 10'd111;
            5'd3:    return 10'd123;
            5'd4:    return 10'd136;
            5'd5:    return 10'd150;
            5'd6:    return 10'd165;
            5'd7:    return 10'd183;
            5'd8:    return 10'd202;
            5'd9:    return 10'd223;
            5'd10:   return 10'd246;
            5'd11:   return 10'd272;
            5'd12:   return 10'd300;
            5'd13:   return 10'd331;
            5'd14:   return 10'd365;
            5'd15:   return 10'd403;
            5'd16:   return 10'd445;
            5'd17:   return 10'd492;
            5'd18:   return 10'd543;
            5'd19:   return 10'd600;
            5'd20:   return 10'd662;
            default: return 10'd1023;
        endcase
    endfunction

    // Magnitude with -32768 clamped so it fits 15 bits.
    function automatic logic [14:0] abs_sat(input logic signed [15:0] s);
        if (s == 16'sh8000) return 15'h7fff;
        return s[15] ? 15'(-s) : 15'(s);
    endfunction

endpackage

// File: rtl/swara_zc_counter.sv
// Hysteretic zero-crossing counter: counts rising crossings of +/-HYST.
// Ports: clk, rst_n, clear, sample_en, sample[15:0] in; count[9:0] out.
module swara_zc_counter
    import swara_dec_pkg::*;
#(
    parameter int HYST = 256
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               sample_en,
    input  logic signed [15:0] sample,
    output logic        [9:0]  count
);

    localparam logic signed [15:0] HI = 16'(HYST);
    localparam logic signed [15:0] LO = -HI;

    logic flag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag  <= 1'b0;
            count <= '0;
        end else if (clear) begin
            flag  <= 1'b0;
            count <= '0;
        end else if (sample_en) begin
            if (sample > HI) begin
                flag <= 1'b1;
                if (!flag && count != ZC_MAX)
                    count <= count + 10'd1;
            end else if (sample < LO) begin
                flag <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/swara_decoder.sv
// Swara decoder: counts zero crossings over one note slot, maps the count to
// a note index through a threshold table and classifies the slot envelope.
// Ports: clk, rst_n, in_sample/in_valid/in_ready (sample stream),
//        out_swara/out_win/out_valid/out_ready (result handshake).
module swara_decoder
    import swara_dec_pkg::*;
#(
    parameter int FS     = 44100,
    parameter int N_SAMP = 13230,
    parameter int WN     = 120,
    parameter int HYST   = 256
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic signed [15:0] in_sample,
    input  logic               in_valid,
    output logic               in_ready,
    output logic        [4:0]  out_swara,
    output logic        [1:0]  out_win,
    output logic               out_valid,
    input  logic               out_ready
);

    if (N_SAMP < 2 * WN + 1 || N_SAMP > 16384 || N_SAMP > FS) begin : g_bad_cfg
        $error("swara_decoder: slot must fit 14 bits, one second and both windows");
    end

    localparam logic [13:0] LAST     = 14'(N_SAMP - 1);
    localparam logic [13:0] HEAD_END = 14'(WN);
    localparam logic [13:0] TAIL_BEG = 14'(N_SAMP - WN);

    state_e      state;
    logic [13:0] slot_cnt;
    logic [14:0] head_pk;
    logic [14:0] mid_pk;
    logic [14:0] tail_pk;
    logic [14:0] mag;
    logic [4:0]  k;
    logic [4:0]  hits;
    logic [9:0]  zc_count;
    logic        accept;
    logic        done;
    logic        head_low;
    logic        tail_low;

    assign accept   = in_valid && in_ready;
    assign done     = (state == ST_OUT) && out_valid && out_ready;
    assign mag      = abs_sat(in_sample);
    assign head_low = {head_pk, 1'b0} < {1'b0, mid_pk};
    assign tail_low = {tail_pk, 1'b0} < {1'b0, mid_pk};

    swara_zc_counter #(
        .HYST(HYST)
    ) u_zc (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (done),
        .sample_en(accept),
        .sample   (in_sample),
        .count    (zc_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_ACCUM;
            slot_cnt  <= '0;
            head_pk   <= '0;
            mid_pk    <= '0;
            tail_pk   <= '0;
            k         <= '0;
            hits      <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_swara <= '0;
            out_win   <= '0;
        end else begin
            unique case (state)
                ST_ACCUM: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        if (slot_cnt < HEAD_END) begin
                            if (mag > head_pk) head_pk <= mag;
                        end else if (slot_cnt >= TAIL_BEG) begin
                            if (mag > tail_pk) tail_pk <= mag;
                        end else begin
                            if (mag > mid_pk) mid_pk <= mag;
                        end
                        if (slot_cnt == LAST) begin
                            slot_cnt <= '0;
                            state    <= ST_SEARCH;
                            in_ready <= 1'b0;
                            k        <= 5'd1;
                            hits     <= '0;
                        end else begin
                            slot_cnt <= slot_cnt + 14'd1;
                        end
                    end
                end
                ST_SEARCH: begin
                    if (zc_count >= th(k)) hits <= hits + 5'd1;
                    if (k == 5'(N_TH)) state <= ST_OUT;
                    else               k     <= k + 5'd1;
                end
                ST_OUT: begin
                    // First OUT cycle latches the result; hits is final here.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        out_swara <= (zc_count < 10'(SILENT_MIN)) ? SWARA_DC : hits;
                        out_win   <= {tail_low, head_low};
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_ACCUM;
                        in_ready  <= 1'b1;
                        head_pk   <= '0;
                        mid_pk    <= '0;
                        tail_pk   <= '0;
                        k         <= '0;
                        hits      <= '0;
                    end
                end
                default: begin
                    state    <= ST_ACCUM;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_swara_decoder.sv
// Self-checking bench for swara_decoder: sine, silence and noise slots,
// back-pressure, mid-slot reset; results checked through a scoreboard.
module tb_swara_decoder;

    localparam int    N   = 13230;
    localparam int    WN  = 120;
    localparam real   AMP = 29490.0;
    localparam real   PI2 = 6.283185307179586;

    logic               clk = 1'b0;
    logic               rst_n;
    logic signed [15:0] in_sample;
    logic               in_valid;
    logic               in_ready;
    logic        [4:0]  out_swara;
    logic        [1:0]  out_win;
    logic               out_valid;
    logic               out_ready;

    typedef struct {
        int id;
        int sw;
        int win;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   hold_req = 0;

    swara_decoder dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_sample(in_sample),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_swara(out_swara),
        .out_win  (out_win),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // kind: 0 sine, 1 zeros, 2 noise; ramp: 0 none, 1 head, 2 head+tail
    function automatic logic signed [15:0] gen(input int kind, input real f,
                                               input int ramp, input int n);
        real g;
        real v;
        int  r;
        if (kind == 1) return 16'sd0;
        if (kind == 2) begin
            if (n == 6000) return 16'sh8000;
            r = int'($urandom_range(400, 0)) - 200;
            return 16'(r);
        end
        g = 1.0;
        if (ramp >= 1 && n < WN) g = 0.4 * real'(n + 1) / real'(WN);
        if (ramp == 2 && n >= N - WN) g = 0.4 * real'(N - n) / real'(WN);
        v = AMP * g * $sin(PI2 * f * real'(n) / 44100.0);
        return 16'($rtoi(v));
    endfunction

    task automatic send(input int kind, input real f, input int ramp,
                        input int nsamp, input bit bub);
        int guard;
        for (int n = 0; n < nsamp; n++) begin
            if (bub && (n % 97) == 50) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            in_sample = gen(kind, f, ramp, n);
            in_valid  = 1'b1;
            guard = 0;
            while (!in_ready && guard < 2000) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 2000) begin
                check("ready_timeout", 0, 1);
                break;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_result(input string tag);
        int lat = 0;
        int bad = 0;
        while (lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid) break;
            if (in_ready) bad++;
        end
        check({"latency_", tag}, lat, 21);
        check({"search_ready_", tag}, bad, 0);
        @(negedge clk);
    endtask

    task automatic push(input int id, input int sw, input int win);
        exp_t e;
        e.id  = id;
        e.sw  = sw;
        e.win = win;
        sb.push_back(e);
    endtask

    // Result monitor: owns out_ready, applies back-pressure on request.
    initial begin
        bit         holding = 1'b0;
        int         hold_left = 0;
        logic [4:0] cap_sw = '0;
        logic [1:0] cap_win = '0;
        exp_t       e;
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid) begin
                if (!holding && hold_req > 0) begin
                    holding   = 1'b1;
                    hold_left = hold_req;
                    hold_req  = 0;
                    cap_sw    = out_swara;
                    cap_win   = out_win;
                    out_ready = 1'b0;
                end else if (holding && hold_left > 0) begin
                    check("hold_stable",
                          int'({in_ready, out_valid, out_swara, out_win}),
                          int'({1'b0, 1'b1, cap_sw, cap_win}));
                    hold_left--;
                end else begin
                    holding   = 1'b0;
                    out_ready = 1'b1;
                    if (sb.size() == 0) begin
                        check("unexpected_result", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check($sformatf("swara_slot%0d", e.id), int'(out_swara), e.sw);
                        check($sformatf("win_slot%0d", e.id), int'(out_win), e.win);
                    end
                end
            end
        end
    end

    initial begin
        int guard;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sample = '0;
        #1;
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_swara", int'(out_swara), 0);
        check("rst_out_win", int'(out_win), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_ready_low", int'(in_ready), 0);
        @(posedge clk);
        #1;
        check("first_edge_ready", int'(in_ready), 1);
        @(negedge clk);

        hold_req = 50;
        push(1, 0, 0);
        send(0, 320.0, 0, N, 1'b0);
        wait_result("320hz");

        push(2, 7, 1);
        send(0, 640.0, 1, N, 1'b0);
        wait_result("640hz");

        send(0, 320.0, 0, 6000, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", int'(in_ready), 0);
        check("mid_rst_out_valid", int'(out_valid), 0);
        check("mid_rst_out_swara", int'(out_swara), 0);
        check("mid_rst_out_win", int'(out_win), 0);
        @(negedge clk);
        rst_n = 1'b1;

        push(3, 20, 3);
        send(0, 2311.0, 2, N, 1'b0);
        wait_result("2311hz");

        push(4, 31, 0);
        send(1, 0.0, 0, N, 1'b0);
        wait_result("zeros");

        push(5, 31, 3);
        send(2, 0.0, 0, N, 1'b1);
        wait_result("noise");

        guard = 0;
        while (sb.size() != 0 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        check("scoreboard_drain", sb.size(), 0);
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
